// File: rtl/code_entry_controller.sv
// Keypad front end for the detonator control path: debounces ten active-low digit
// keys, assembles a 4-digit BCD entry and checks it against a programmable code.
module code_entry_controller #(
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter int          MAX_TRIES       = 3,
  parameter int          LOCK_CYCLES     = 16,
  parameter logic [15:0] INIT_CODE       = 16'h2580
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] A,
  input  logic       sure,
  input  logic       setup,
  input  logic       clear,
  output logic       key_valid,
  output logic [3:0] m_disp,
  output logic [2:0] digit_cnt,
  output logic       match,
  output logic       mismatch,
  output logic       prog_done,
  output logic       locked,
  output logic       programming
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {S_ENTRY, S_PROGRAM, S_COMPARE, S_LOCKED} state_t;

  state_t           r_state;
  logic [9:0]       r_a_q;
  logic [CNT_W-1:0] r_stab_cnt;
  logic             r_armed;
  logic [3:0]       r_key_digit;
  logic [15:0]      r_entry;
  logic [15:0]      r_code;
  logic [TRY_W-1:0] r_tries;
  logic [TMR_W-1:0] r_timer;

  logic [9:0] w_low;
  logic       w_stable;
  logic       w_one_low;
  logic       w_fire;
  logic       w_collect;
  logic       w_last_try;

  function automatic logic [3:0] f_encode(input logic [9:0] low);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 10; i++)
      if (low[i]) d = 4'(i);
    return d;
  endfunction

  assign w_low      = ~r_a_q;
  assign w_stable   = (r_stab_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_one_low  = (w_low != 10'd0) && ((w_low & (w_low - 10'd1)) == 10'd0);
  assign w_fire     = w_stable && r_armed && w_one_low;
  assign w_collect  = (r_state == S_ENTRY) || (r_state == S_PROGRAM);
  assign w_last_try = (r_tries == TRY_W'(MAX_TRIES - 1));

  // Debounce stage: a press is accepted only after a stable all-released pattern
  // has armed the debouncer; firing disarms it even when the key is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_q       <= '1;
      r_stab_cnt  <= '0;
      r_armed     <= 1'b0;
      r_key_digit <= 4'd0;
      key_valid   <= 1'b0;
    end else begin
      r_a_q     <= A;
      key_valid <= 1'b0;
      if (A != r_a_q)
        r_stab_cnt <= '0;
      else if (!w_stable)
        r_stab_cnt <= r_stab_cnt + CNT_W'(1);
      if (w_stable && (&r_a_q))
        r_armed <= 1'b1;
      else if (w_fire) begin
        r_armed     <= 1'b0;
        r_key_digit <= f_encode(w_low);
        key_valid   <= w_collect;
      end
    end
  end

  // Sequencer stage: entry collection, comparison, reprogramming and lockout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_ENTRY;
      r_entry     <= 16'd0;
      r_code      <= INIT_CODE;
      r_tries     <= '0;
      r_timer     <= '0;
      m_disp      <= 4'd0;
      digit_cnt   <= 3'd0;
      match       <= 1'b0;
      mismatch    <= 1'b0;
      prog_done   <= 1'b0;
      locked      <= 1'b0;
      programming <= 1'b0;
    end else begin
      match     <= 1'b0;
      mismatch  <= 1'b0;
      prog_done <= 1'b0;
      if (key_valid) m_disp <= r_key_digit;
      case (r_state)
        S_ENTRY, S_PROGRAM: begin
          if (clear) begin
            r_entry     <= 16'd0;
            digit_cnt   <= 3'd0;
            r_state     <= S_ENTRY;
            programming <= 1'b0;
          end else if (sure) begin
            if (digit_cnt == 3'd4 && r_state == S_ENTRY) begin
              r_state <= S_COMPARE;
            end else begin
              r_entry     <= 16'd0;
              digit_cnt   <= 3'd0;
              programming <= 1'b0;
              r_state     <= S_ENTRY;
              if (digit_cnt == 3'd4) begin
                r_code    <= r_entry;
                prog_done <= 1'b1;
              end else begin
                mismatch <= 1'b1;
                if (r_state == S_ENTRY) begin
                  r_tries <= r_tries + TRY_W'(1);
                  if (w_last_try) begin
                    r_state <= S_LOCKED;
                    locked  <= 1'b1;
                    r_timer <= TMR_W'(LOCK_CYCLES - 1);
                  end
                end
              end
            end
          end else if (key_valid && digit_cnt != 3'd4) begin
            r_entry   <= {r_entry[11:0], r_key_digit};
            digit_cnt <= digit_cnt + 3'd1;
          end
        end
        S_COMPARE: begin
          r_entry   <= 16'd0;
          digit_cnt <= 3'd0;
          if (r_entry == r_code) begin
            match   <= 1'b1;
            r_tries <= '0;
            if (setup) begin
              r_state     <= S_PROGRAM;
              programming <= 1'b1;
            end else begin
              r_state <= S_ENTRY;
            end
          end else begin
            mismatch <= 1'b1;
            r_tries  <= r_tries + TRY_W'(1);
            if (w_last_try) begin
              r_state <= S_LOCKED;
              locked  <= 1'b1;
              r_timer <= TMR_W'(LOCK_CYCLES - 1);
            end else begin
              r_state <= S_ENTRY;
            end
          end
        end
        S_LOCKED: begin
          if (r_timer == '0) begin
            r_state <= S_ENTRY;
            locked  <= 1'b0;
            r_tries <= '0;
          end else begin
            r_timer <= r_timer - TMR_W'(1);
          end
        end
        default: r_state <= S_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_code_entry_controller.sv
// Directed bench for code_entry_controller: table of entry attempts plus
// hand-written sequences for debounce, lockout and reset corner cases.
module tb_code_entry_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] A;
  logic       sure, setup, clear;
  logic       key_valid;
  logic [3:0] m_disp;
  logic [2:0] digit_cnt;
  logic       match, mismatch, prog_done, locked, programming;

  int checks = 0;
  int errors = 0;
  int kv_cnt = 0, res_cnt = 0, lock_cnt = 0, excl_bad = 0;

  code_entry_controller #(
    .DEBOUNCE_CYCLES(4), .MAX_TRIES(3), .LOCK_CYCLES(16), .INIT_CODE(16'h2580)
  ) dut (
    .clk(clk), .rst(rst), .A(A), .sure(sure), .setup(setup), .clear(clear),
    .key_valid(key_valid), .m_disp(m_disp), .digit_cnt(digit_cnt),
    .match(match), .mismatch(mismatch), .prog_done(prog_done),
    .locked(locked), .programming(programming)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) kv_cnt++;
      if (match || mismatch || prog_done) res_cnt++;
      if (locked) lock_cnt++;
      if (int'(match) + int'(mismatch) + int'(prog_done) > 1) excl_bad++;
    end
  end

  typedef struct {
    logic [19:0] digits;
    int          ndig;
    logic        setup;
    int          lat;
    logic        exp_match;
    logic        exp_mm;
    logic        exp_pd;
    logic        exp_prog;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int d);
    A = ~(10'd1 << d);
    cyc(10);
    A = '1;
    cyc(10);
  endtask

  task automatic enter(input logic [19:0] digits, input int n);
    logic [19:0] v;
    for (int k = 0; k < n; k++) begin
      v = digits >> (4 * (n - 1 - k));
      press(int'(v[3:0]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; A = '1; sure = 1'b0; setup = 1'b0; clear = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(10);
  endtask

  // Full entry + sure; checks the result pulse exactly two cycles after sure.
  task automatic try_code(input logic [15:0] code, input string name,
                          input logic em, input logic emm);
    enter({4'h0, code}, 4);
    sure = 1'b1;
    cyc(1);
    sure = 1'b0;
    chk({name, "_early"}, int'(match | mismatch), 0);
    cyc(1);
    chk({name, "_match"}, int'(match), int'(em));
    chk({name, "_mismatch"}, int'(mismatch), int'(emm));
    cyc(3);
  endtask

  initial begin
    logic [19:0] v;
    int kv0, r0, nexp;

    tbl[0] = '{20'h02580, 4, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{20'h00012, 2, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{20'h25809, 5, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{20'h02580, 4, 1'b1, 2, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{20'h01234, 4, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{20'h02580, 4, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{20'h01234, 4, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; A = '1; sure = 1'b0; setup = 1'b0; clear = 1'b0;
    cyc(2);
    chk("reset_outputs",
        int'({key_valid, m_disp, digit_cnt, match, mismatch, prog_done, locked, programming}), 0);
    rst = 1'b0;
    cyc(10);

    // Bouncing key 7, then a two-key chord, then clear after three digits.
    kv0 = kv_cnt;
    A = ~(10'd1 << 7); cyc(2);
    A = '1;            cyc(2);
    A = ~(10'd1 << 7); cyc(2);
    cyc(10);
    A = '1;            cyc(10);
    chk("bounce_kv_count", kv_cnt - kv0, 1);
    chk("bounce_m_disp", int'(m_disp), 7);
    chk("bounce_digit_cnt", int'(digit_cnt), 1);
    A = ~10'b0000011000; cyc(10);
    A = '1;              cyc(10);
    chk("chord_kv_count", kv_cnt - kv0, 1);
    press(1);
    press(2);
    chk("three_digits", int'(digit_cnt), 3);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_digit_cnt", int'(digit_cnt), 0);

    // Table of entry attempts starting from the reset code.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      setup = tbl[i].setup;
      enter(tbl[i].digits, tbl[i].ndig);
      nexp = (tbl[i].ndig > 4) ? 4 : tbl[i].ndig;
      v = tbl[i].digits;
      chk($sformatf("v%0d_digit_cnt", i), int'(digit_cnt), nexp);
      chk($sformatf("v%0d_m_disp", i), int'(m_disp), int'(v[3:0]));
      r0 = res_cnt;
      sure = 1'b1;
      cyc(tbl[i].lat);
      sure = 1'b0;
      chk($sformatf("v%0d_match", i), int'(match), int'(tbl[i].exp_match));
      chk($sformatf("v%0d_mismatch", i), int'(mismatch), int'(tbl[i].exp_mm));
      chk($sformatf("v%0d_prog_done", i), int'(prog_done), int'(tbl[i].exp_pd));
      cyc(3);
      setup = 1'b0;
      chk($sformatf("v%0d_pulses", i), res_cnt - r0, 1);
      chk($sformatf("v%0d_cnt_after", i), int'(digit_cnt), 0);
      chk($sformatf("v%0d_programming", i), int'(programming), int'(tbl[i].exp_prog));
    end

    // Three wrong codes lock out for 16 cycles; keys are discarded meanwhile.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      enter(20'h01111, 4);
      if (k == 2) lock_cnt = 0;
      sure = 1'b1;
      cyc(1);
      sure = 1'b0;
      cyc(1);
      chk($sformatf("lock_try%0d_mismatch", k), int'(mismatch), 1);
      chk($sformatf("lock_try%0d_locked", k), int'(locked), (k == 2) ? 1 : 0);
      if (k < 2) cyc(3);
    end
    kv0 = kv_cnt;
    press(6);
    cyc(10);
    chk("lock_key_ignored", kv_cnt - kv0, 0);
    chk("lock_duration", lock_cnt, 16);
    chk("lock_released", int'(locked), 0);
    try_code(16'h2580, "after_lock", 1'b1, 1'b0);

    // Reset in the middle of PROGRAM restores the initial code.
    do_reset();
    setup = 1'b1;
    try_code(16'h2580, "to_program", 1'b1, 1'b0);
    setup = 1'b0;
    chk("in_program", int'(programming), 1);
    press(1);
    press(2);
    chk("program_digits", int'(digit_cnt), 2);
    rst = 1'b1;
    cyc(1);
    chk("midprog_reset_outputs",
        int'({key_valid, m_disp, digit_cnt, match, mismatch, prog_done, locked, programming}), 0);
    rst = 1'b0;
    cyc(10);
    try_code(16'h2580, "after_reset", 1'b1, 1'b0);

    chk("exclusive_pulses", excl_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
